// File: rtl/char_uart_tx.sv
// UART transmitter (8N1) fed by a small character FIFO.
// Define CHAR_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module char_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    char_in,
  input  logic                          char_valid,
  output logic                          char_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef CHAR_UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [BW-1:0]   r_baud, w_baud_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_data, w_data_nxt;
  logic            r_tx, w_tx_nxt;
  logic            r_busy;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic            r_ready;
  logic            r_overflow;

  logic            w_push, w_pop, w_baud_end;

  assign w_push     = char_valid & r_ready;
  assign w_pop      = (r_state == StIdle) & (r_count != '0);
  assign w_baud_end = (r_baud == BW'(CLKS_PER_BIT - 1));

  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // FIFO bookkeeping; ready is registered from the post-edge count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != CW'(FIFO_DEPTH));
      if (char_valid && !r_ready) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= char_in;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_data_nxt  = r_data;
    if (r_state == StIdle || w_baud_end) begin
      w_baud_nxt = '0;
    end else begin
      w_baud_nxt = r_baud + 1'b1;
    end
    case (r_state)
      StIdle: begin
        if (w_pop) begin
          w_state_nxt = StStart;
          w_data_nxt  = r_mem[r_rd_ptr];
        end
      end
      StStart: begin
        if (w_baud_end) begin
          w_state_nxt = StData;
          w_bit_nxt   = 3'd0;
        end
      end
      StData: begin
        if (w_baud_end) begin
          if (r_bit == 3'd7) begin
`ifdef CHAR_UART_TX_PARITY_EN
            w_state_nxt = StParity;
`else
            w_state_nxt = StStop;
`endif
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
`ifdef CHAR_UART_TX_PARITY_EN
      StParity: begin
        if (w_baud_end) w_state_nxt = StStop;
      end
`endif
      StStop: begin
        if (w_baud_end) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Line level is decoded from the next state so tx leaves a flop
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      StStart:  w_tx_nxt = 1'b0;
      StData:   w_tx_nxt = w_data_nxt[w_bit_nxt];
`ifdef CHAR_UART_TX_PARITY_EN
      StParity: w_tx_nxt = ^w_data_nxt;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_data  <= 8'd0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_data  <= w_data_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != StIdle);
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign char_ready = r_ready;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_char_uart_tx.sv
// Randomized + directed bench for char_uart_tx against a frame-timing reference model.
module tb_char_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef CHAR_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char_in = 8'd0;
  logic       char_valid = 1'b0;
  logic       char_ready, tx, busy, overflow;
  logic [2:0] fifo_count;

  char_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted characters and a countdown of the frame on the wire
  logic [7:0] mq[$];
  int         m_left = 0;
  logic [7:0] m_cur = 8'd0;
  logic       m_ovf = 1'b0;
  logic       m_pop, m_acc;

  function automatic logic exp_tx();
    int idx;
    if (m_left == 0) return 1'b1;
    idx = (FRAME - m_left) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_cur[idx-1];
    if (idx == NBITS - 1) return 1'b1;
    return ^m_cur;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_left = 0;
      m_ovf  = 1'b0;
    end else begin
      m_pop = (m_left == 0) && (mq.size() > 0);
      m_acc = char_valid && (mq.size() < DEPTH);
      if (char_valid && !m_acc) m_ovf = 1'b1;
      if (m_left > 0) m_left--;
      if (m_pop) begin
        m_cur  = mq.pop_front();
        m_left = FRAME;
      end
      if (m_acc) mq.push_back(char_in);
    end
  end

  // Per-cycle comparison plus a count of frames the DUT starts
  int   dut_frames = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      check("tx",         32'(tx),         32'(exp_tx()));
      check("busy",       32'(busy),       32'(m_left > 0));
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("char_ready", 32'(char_ready), 32'(mq.size() != DEPTH));
      check("overflow",   32'(overflow),   32'(m_ovf));
    end
    if (busy && !busy_prev) dut_frames++;
    busy_prev = busy;
  end

  task automatic push(input logic [7:0] c);
    char_valid = 1'b1;
    char_in    = c;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
  endtask

  int base, cnt, peak;

  initial begin
    // Reset
    idle(3);
    check("rst_tx",    32'(tx), 1);
    check("rst_busy",  32'(busy), 0);
    check("rst_ready", 32'(char_ready), 1);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_ovf",   32'(overflow), 0);
    rst_n = 1'b1;
    idle(20);

    // Single char: tx falls two edges after the push, busy spans exactly one frame
    push(8'h41);
    check("lat_edge1", 32'(tx), 1);
    @(negedge clk);
    check("lat_edge2", 32'(tx), 0);
    cnt = 1;
    while (busy && cnt < 200) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("busy_len", 32'(cnt), 32'(FRAME));
    idle(5);

    // Burst of three
    base = dut_frames;
    peak = 0;
    push(8'h41);
    push(8'h42);
    push(8'h43);
    for (int i = 0; i < 3 * (FRAME + 1) + 10; i++) begin
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      @(negedge clk);
    end
    check("burst_peak",   32'(peak), 2);
    check("burst_frames", 32'(dut_frames - base), 3);

    // Overflow: 6 pushes while frame 1 is on the wire
    base = dut_frames;
    push(8'h30);
    idle(2);
    for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
    check("ovf_ready", 32'(char_ready), 0);
    check("ovf_flag",  32'(overflow), 1);
    idle(6 * (FRAME + 1));
    check("ovf_frames", 32'(dut_frames - base), 5);
    check("ovf_sticky", 32'(overflow), 1);
    do_reset();
    idle(2);

    // Push on the pop edge keeps the count at 1
    base = dut_frames;
    push(8'h61);
    push(8'h62);
    check("pp_count", 32'(fifo_count), 1);
    idle(2 * (FRAME + 1) + 5);
    check("pp_frames", 32'(dut_frames - base), 2);

    // Reset during data bit 3 of 8'h45 with two characters queued
    push(8'h45);
    push(8'h46);
    push(8'h47);
    check("mid_queued", 32'(fifo_count), 2);
    idle(16);
    check("mid_bit3", 32'(tx), 0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_async_tx",   32'(tx), 1);
    check("mid_async_busy", 32'(busy), 0);
    idle(2);
    rst_n = 1'b1;
    base = dut_frames;
    idle(100);
    check("mid_count",  32'(fifo_count), 0);
    check("mid_frames", 32'(dut_frames - base), 0);

    // Randomized traffic: alternate dense bursts and sparse input
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 300; i++) begin
        char_valid = ($urandom_range(0, (blk % 2 == 0) ? 5 : 60) == 0);
        char_in    = 8'($urandom);
        @(negedge clk);
      end
      char_valid = 1'b0;
      if (blk == 2) do_reset();
    end
    idle(DEPTH * (FRAME + 1) + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/char_uart_tx.md
# char_uart_tx

Serial output stage that consumes the 8-bit ASCII characters produced by the lowercase-to-uppercase converter and transmits them on a single line as UART frames (8N1, optional parity). A small FIFO absorbs bursts from the converter. The converter's output bus drives `char_in` directly, and a one-cycle `char_valid` strobe marks each new character. The `tx` line leaves the chip.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 8: character FIFO depth; must be a power of two, ≥ 2.

Ports:
- `clk` in 1: rising-edge clock; the only clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `char_in` in 8: character from the converter.
- `char_valid` in 1: `char_in` is valid this cycle.
- `char_ready` out 1: FIFO can accept (`!full`).
- `tx` out 1: serial line; idles high.
- `busy` out 1: a frame is in progress (state ≠ IDLE).
- `fifo_count` out $clog2(FIFO_DEPTH)+1: characters currently queued.
- `overflow` out 1: sticky flag; set when `char_valid` arrives while `char_ready` is 0.

## Operation
- Push: on an edge where `char_valid && char_ready`, `char_in` is written to the FIFO.
- Pop: in IDLE, on an edge where the FIFO is non-empty, the head is loaded into the shift register and the FSM enters START.
- A push and a pop on the same edge are both performed, and `fifo_count` is unchanged.
- A push while full is dropped and `overflow` is set to 1. `overflow` stays 1 until reset; the FIFO contents are unaffected.
- FSM states:
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: 8 bits, LSB first.
  - PARITY: present only with `CHAR_UART_TX_PARITY_EN`.
  - STOP: `tx`=1.
- Each non-IDLE state bit lasts exactly `CLKS_PER_BIT` cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1. The bit index runs 0..7 inside DATA.
- Transitions:
  - IDLE → START on pop.
  - START → DATA.
  - DATA(bit 7) → PARITY or STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- IDLE always lasts at least one cycle between frames.
- Data values are not checked; any 8-bit value is sent unchanged.
- Reset values: `tx`=1, `busy`=0, `char_ready`=1, `fifo_count`=0, `overflow`=0, FSM=IDLE, FIFO pointers=0.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronous), the frame is abandoned and the FIFO is emptied.
- FIFO pointers wrap modulo `FIFO_DEPTH`; full/empty are derived from `fifo_count`.

## Timing
- `char_ready` and `fifo_count` are registered and reflect the state after the last edge.
- Latency, FIFO empty and FSM IDLE: with a push on edge N, `fifo_count` is 1 after edge N. The pop happens on edge N+1, so `tx` falls after edge N+1 and `busy` rises after N+1.
- Frame length: 10·`CLKS_PER_BIT` cycles, or 11·`CLKS_PER_BIT` with parity.
- Back-to-back frames with the FIFO non-empty: the period is frame length + 1 cycle (one IDLE cycle).
- Sustained input faster than one character per frame period fills the FIFO. Once full, `char_ready` is 0 until the next pop edge.
- `tx` is driven from a flop; there is no combinational path from `char_in` to `tx`.

## Configuration
- `CHAR_UART_TX_PARITY_EN` defined:
  - PARITY state compiled in, sending the even-parity bit (XOR of the 8 data bits) after DATA.
  - Frame is 11 bits.
- Not defined:
  - PARITY state and the parity logic are absent.
  - Frame is 10 bits (8N1).
- Ports are identical in both builds.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.

- **Reset:** hold `rst_n`=0 for 3 cycles, then release. Required: `tx`=1, `busy`=0, `char_ready`=1, `fifo_count`=0, `overflow`=0; `tx` stays 1 for 20 idle cycles.
- **Single char:** push 8'h41 ('A'). Required:
  - `tx` falls 2 edges after the push.
  - The sampled bit sequence is 0, 1,0,0,0,0,0,1,0, 1, with 4 cycles per bit.
  - `busy` is high for exactly 40 cycles.
  - With `CHAR_UART_TX_PARITY_EN`, parity bit 0 is inserted before the stop bit and `busy` is high for 44 cycles.
- **Burst:** push 8'h41, 8'h42, 8'h43 on consecutive cycles. Required:
  - `fifo_count` peaks at 2.
  - Frames are sent in order with exactly 1 idle cycle between stop and start.
  - Decoded bytes are 41, 42, 43.
- **Overflow:** push 6 characters on consecutive cycles while frame 1 is in progress. Required:
  - `char_ready`=0 once `fifo_count`=4.
  - `overflow`=1 from the first rejected push and stays 1.
  - Exactly the 5 accepted characters are transmitted.
- **Simultaneous push/pop:** with `fifo_count`=1 in IDLE, push on the pop edge. Required: `fifo_count` stays 1 and both characters are transmitted in order.
- **Reset mid-frame:** assert `rst_n`=0 during DATA bit 3 of 8'h45 with 2 characters queued. Required: `tx`=1 asynchronously, and after release `fifo_count`=0 and no further frames are sent.
